sw_debouncer: RTL and testbench



---
 rtl/sw_pkg.sv | 8 +
 rtl/sw_debouncer_if.sv | 16 +
 rtl/sw_dbnc_bit.sv | 57 +++++
 rtl/sw_debouncer.sv | 52 +++++
 tb/tb_sw_debouncer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared widths, default debounce limit and per-bit state encoding for the switch debouncer.
package sw_pkg;
   localparam int NB_SW_DEF              = 4;
   localparam int NB_DBNC_DEF            = 20;
   localparam int NB_GLITCH              = 16;
   localparam int DBNC_LIMIT_100MHZ_10MS = 1000000;
   typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} dbnc_state_t;
endpackage

// File: rtl/sw_debouncer_if.sv
// sw_debouncer_if: switch bus between the raw pins and debounced consumers.
// o_glitch_cnt exists only when SW_GLITCH_CNT_EN is defined.
interface sw_debouncer_if import sw_pkg::*; #(parameter int NB_SW = NB_SW_DEF);
   logic [NB_SW-1:0] i_sw_raw;
   logic [NB_SW-1:0] o_sw;
   logic [NB_SW-1:0] o_rise;
   logic [NB_SW-1:0] o_fall;
`ifdef SW_GLITCH_CNT_EN
   logic [NB_GLITCH-1:0] o_glitch_cnt;
   modport master(output i_sw_raw, input o_sw, o_rise, o_fall, o_glitch_cnt);
   modport slave(input i_sw_raw, output o_sw, o_rise, o_fall, o_glitch_cnt);
`else
   modport master(output i_sw_raw, input o_sw, o_rise, o_fall);
   modport slave(input i_sw_raw, output o_sw, o_rise, o_fall);
`endif
endinterface

// File: rtl/sw_dbnc_bit.sv
// sw_dbnc_bit: 2-FF synchronizer, stability counter, level and edge pulses for one switch bit.
// o_glitch (SW_GLITCH_CNT_EN only) flags a pending change abandoned this cycle.
module sw_dbnc_bit import sw_pkg::*; #(
   parameter int   NB_DBNC    = NB_DBNC_DEF,
   parameter int   DBNC_LIMIT = DBNC_LIMIT_100MHZ_10MS,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_sw,
   output logic o_rise,
`ifdef SW_GLITCH_CNT_EN
   output logic o_glitch,
`endif
   output logic o_fall
);
   localparam logic [NB_DBNC-1:0] LAST = NB_DBNC'(DBNC_LIMIT - 1);
   logic s1_q, s2_q, sw_q, sw_d, rise_q, rise_d, fall_q, fall_d, diff, done;
   logic [NB_DBNC-1:0] cnt_q, cnt_d;
   dbnc_state_t state;
   always_ff @(posedge clock) begin
      if (i_reset) begin
         s1_q   <= RESET_VAL;
         s2_q   <= RESET_VAL;
         sw_q   <= RESET_VAL;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= i_raw;
         s2_q   <= s1_q;
         sw_q   <= sw_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end
   always_comb begin
      state  = (cnt_q == '0) ? ST_STABLE : ST_PENDING;
      diff   = s2_q != sw_q;
      done   = diff && (cnt_q == LAST);
      cnt_d  = (diff && !done) ? cnt_q + 1'b1 : '0;
      sw_d   = done ? s2_q : sw_q;
      rise_d = done && s2_q;
      fall_d = done && !s2_q;
   end
`ifdef SW_GLITCH_CNT_EN
   assign o_glitch = !diff && (state == ST_PENDING);
`else
   logic unused_state;
   assign unused_state = state == ST_PENDING;
`endif
   assign o_sw   = sw_q;
   assign o_rise = rise_q;
   assign o_fall = fall_q;
endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: per-bit synchronize and debounce of board switches with rise/fall pulses.
// SW_GLITCH_CNT_EN adds a saturating count of rejected bounces on o_glitch_cnt.
module sw_debouncer import sw_pkg::*; #(
   parameter int               NB_SW      = NB_SW_DEF,
   parameter int               NB_DBNC    = NB_DBNC_DEF,
   parameter int               DBNC_LIMIT = DBNC_LIMIT_100MHZ_10MS,
   parameter logic [NB_SW-1:0] RESET_VAL  = '0
) (
   input logic          clock,
   input logic          i_reset,
   sw_debouncer_if.slave sw
);
   logic [NB_SW-1:0] lvl, rise, fall;
`ifdef SW_GLITCH_CNT_EN
   logic [NB_SW-1:0] glitch;
`endif
   if (DBNC_LIMIT < 1 || longint'(DBNC_LIMIT) > (longint'(1) << NB_DBNC) - 1) begin : g_bad_limit
      $error("sw_debouncer: DBNC_LIMIT out of range for NB_DBNC");
   end
   for (genvar i = 0; i < NB_SW; i++) begin : g_bit
      sw_dbnc_bit #(
         .NB_DBNC   (NB_DBNC),
         .DBNC_LIMIT(DBNC_LIMIT),
         .RESET_VAL (RESET_VAL[i])
      ) u_bit (
         .clock   (clock),
         .i_reset (i_reset),
         .i_raw   (sw.i_sw_raw[i]),
         .o_sw    (lvl[i]),
         .o_rise  (rise[i]),
`ifdef SW_GLITCH_CNT_EN
         .o_glitch(glitch[i]),
`endif
         .o_fall  (fall[i])
      );
   end
   assign sw.o_sw   = lvl;
   assign sw.o_rise = rise;
   assign sw.o_fall = fall;
`ifdef SW_GLITCH_CNT_EN
   logic [NB_GLITCH-1:0] gcnt_q, gcnt_d;
   logic [NB_GLITCH:0]   gsum;
   always_comb begin
      gsum   = {1'b0, gcnt_q} + (NB_GLITCH + 1)'($countones(glitch));
      gcnt_d = gsum[NB_GLITCH] ? '1 : gsum[NB_GLITCH-1:0];
   end
   always_ff @(posedge clock) begin
      gcnt_q <= i_reset ? '0 : gcnt_d;
   end
   assign sw.o_glitch_cnt = gcnt_q;
`endif
endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: directed scenarios plus randomized run against a sample-window reference model.
module tb_sw_debouncer;
   import sw_pkg::*;
   localparam int NB = 4;
   localparam int L  = 4;
   logic clock = 1'b0;
   logic i_reset = 1'b1;
   always #5 clock = ~clock;
   sw_debouncer_if #(.NB_SW(NB)) bus();
   sw_debouncer #(.NB_SW(NB), .NB_DBNC(8), .DBNC_LIMIT(L), .RESET_VAL(4'h0)) dut (
      .clock  (clock),
      .i_reset(i_reset),
      .sw     (bus)
   );
`ifdef SW_GLITCH_CNT_EN
   logic rst2 = 1'b1;
   sw_debouncer_if #(.NB_SW(NB)) bus2();
   sw_debouncer #(.NB_SW(NB), .NB_DBNC(4), .DBNC_LIMIT(2), .RESET_VAL(4'h0)) dut2 (
      .clock  (clock),
      .i_reset(rst2),
      .sw     (bus2)
   );
`endif
   int n_run = 0;
   int n_fail = 0;
   logic [NB-1:0] m_s1, m_s2, m_sw, m_rise, m_fall;
   logic [NB-1:0] hist[$];
   int m_glitch;

   // s2 samples seen since reset; a bit is accepted once the last L samples all oppose its level
   task automatic step(input logic [NB-1:0] raw, input logic rst);
      logic [NB-1:0] cur, acc, gl;
      @(negedge clock);
      bus.i_sw_raw = raw;
      i_reset = rst;
      @(posedge clock);
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_sw = '0; m_rise = '0; m_fall = '0;
         hist.delete();
         m_glitch = 0;
      end else begin
         cur = m_s2;
         acc = '0;
         gl = '0;
         hist.push_back(cur);
         if (hist.size() > L) void'(hist.pop_front());
         for (int b = 0; b < NB; b++) begin
            if (hist.size() >= L) begin
               acc[b] = 1'b1;
               for (int k = 0; k < L; k++)
                  if (hist[hist.size()-1-k][b] == m_sw[b]) acc[b] = 1'b0;
            end
            if (hist.size() >= 2 && hist[hist.size()-2][b] != m_sw[b] && cur[b] == m_sw[b]) gl[b] = 1'b1;
         end
         m_rise = acc & cur;
         m_fall = acc & ~cur;
         m_sw = (m_sw & ~acc) | (cur & acc);
         m_glitch = m_glitch + $countones(gl);
         if (m_glitch > 65535) m_glitch = 65535;
         m_s2 = m_s1;
         m_s1 = raw;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) step(4'hF, 1'b1);
      n_run++; if (bus.o_sw !== 4'h0) begin n_fail++; $display("FAIL reset_sw: got %h exp 0", bus.o_sw); end
      n_run++; if (bus.o_rise !== 4'h0) begin n_fail++; $display("FAIL reset_rise: got %h exp 0", bus.o_rise); end
      n_run++; if (bus.o_fall !== 4'h0) begin n_fail++; $display("FAIL reset_fall: got %h exp 0", bus.o_fall); end
`ifdef SW_GLITCH_CNT_EN
      n_run++; if (bus.o_glitch_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_glitch: got %h exp 0", bus.o_glitch_cnt); end
`endif
      for (int k = 0; k < 3; k++) step(4'h0, 1'b0);
   endtask

   task automatic test_clean_rise();
      for (int k = 1; k <= 7; k++) begin
         step(4'h1, 1'b0);
         n_run++; if (bus.o_sw !== ((k >= 6) ? 4'h1 : 4'h0)) begin n_fail++; $display("FAIL rise_sw edge%0d: got %h exp %h", k, bus.o_sw, (k >= 6) ? 4'h1 : 4'h0); end
         n_run++; if (bus.o_rise !== ((k == 6) ? 4'h1 : 4'h0)) begin n_fail++; $display("FAIL rise_pulse edge%0d: got %h exp %h", k, bus.o_rise, (k == 6) ? 4'h1 : 4'h0); end
      end
   endtask

   task automatic test_bounce();
      logic [NB-1:0] pat[4];
      pat = '{4'h3, 4'h1, 4'h3, 4'h1};
      for (int p = 0; p < 4; p++)
         for (int r = 0; r < 2; r++) begin
            step(pat[p], 1'b0);
            n_run++; if (bus.o_sw !== 4'h1) begin n_fail++; $display("FAIL bounce_hold: got %h exp 1", bus.o_sw); end
         end
      for (int k = 1; k <= 6; k++) begin
         step(4'h3, 1'b0);
         n_run++; if (bus.o_sw[1] !== (k == 6)) begin n_fail++; $display("FAIL bounce_sw1 edge%0d: got %b exp %b", k, bus.o_sw[1], k == 6); end
      end
`ifdef SW_GLITCH_CNT_EN
      n_run++; if (bus.o_glitch_cnt !== 16'd2) begin n_fail++; $display("FAIL bounce_glitch: got %0d exp 2", bus.o_glitch_cnt); end
`endif
   endtask

   task automatic test_fall_simul();
      for (int k = 0; k < 6; k++) step(4'hF, 1'b0);
      n_run++; if (bus.o_sw !== 4'hF) begin n_fail++; $display("FAIL fall_pre: got %h exp F", bus.o_sw); end
      for (int k = 1; k <= 7; k++) begin
         step(4'h3, 1'b0);
         n_run++; if (bus.o_sw !== ((k >= 6) ? 4'h3 : 4'hF)) begin n_fail++; $display("FAIL fall_sw edge%0d: got %h exp %h", k, bus.o_sw, (k >= 6) ? 4'h3 : 4'hF); end
         n_run++; if (bus.o_fall !== ((k == 6) ? 4'hC : 4'h0)) begin n_fail++; $display("FAIL fall_pulse edge%0d: got %h exp %h", k, bus.o_fall, (k == 6) ? 4'hC : 4'h0); end
         n_run++; if (bus.o_rise !== 4'h0) begin n_fail++; $display("FAIL fall_rise edge%0d: got %h exp 0", k, bus.o_rise); end
      end
   endtask

   task automatic test_reset_mid_pending();
      step(4'h0, 1'b1);
      for (int k = 0; k < 3; k++) step(4'h0, 1'b0);
      for (int k = 0; k < 4; k++) step(4'h1, 1'b0);
      step(4'h1, 1'b1);
      n_run++; if (bus.o_sw !== 4'h0) begin n_fail++; $display("FAIL midrst_sw: got %h exp 0", bus.o_sw); end
      n_run++; if (bus.o_rise !== 4'h0) begin n_fail++; $display("FAIL midrst_rise: got %h exp 0", bus.o_rise); end
`ifdef SW_GLITCH_CNT_EN
      n_run++; if (bus.o_glitch_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_glitch: got %h exp 0", bus.o_glitch_cnt); end
`endif
      for (int k = 1; k <= 6; k++) begin
         step(4'h1, 1'b0);
         n_run++; if (bus.o_sw !== ((k == 6) ? 4'h1 : 4'h0)) begin n_fail++; $display("FAIL midrst_after edge%0d: got %h exp %h", k, bus.o_sw, (k == 6) ? 4'h1 : 4'h0); end
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] raw;
      raw = 4'h1;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
         step(raw, $urandom_range(0, 199) == 0);
         n_run++; if (bus.o_sw !== m_sw) begin n_fail++; $display("FAIL rand_sw cyc%0d: got %h exp %h", c, bus.o_sw, m_sw); end
         n_run++; if (bus.o_rise !== m_rise) begin n_fail++; $display("FAIL rand_rise cyc%0d: got %h exp %h", c, bus.o_rise, m_rise); end
         n_run++; if (bus.o_fall !== m_fall) begin n_fail++; $display("FAIL rand_fall cyc%0d: got %h exp %h", c, bus.o_fall, m_fall); end
`ifdef SW_GLITCH_CNT_EN
         n_run++; if (bus.o_glitch_cnt !== 16'(m_glitch)) begin n_fail++; $display("FAIL rand_glitch cyc%0d: got %0d exp %0d", c, bus.o_glitch_cnt, m_glitch); end
`endif
      end
   endtask

`ifdef SW_GLITCH_CNT_EN
   task automatic test_saturation();
      @(negedge clock); bus2.i_sw_raw = 4'h0; rst2 = 1'b1;
      @(negedge clock); rst2 = 1'b0;
      for (int c = 0; c < 17600; c++) begin
         @(negedge clock); bus2.i_sw_raw = 4'hF;
         @(negedge clock); bus2.i_sw_raw = 4'h0;
      end
      repeat (4) @(negedge clock);
      n_run++; if (bus2.o_glitch_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_glitch: got %h exp FFFF", bus2.o_glitch_cnt); end
      n_run++; if (bus2.o_sw !== 4'h0) begin n_fail++; $display("FAIL sat_sw: got %h exp 0", bus2.o_sw); end
   endtask
`endif

   initial begin
      bus.i_sw_raw = '0;
`ifdef SW_GLITCH_CNT_EN
      bus2.i_sw_raw = '0;
`endif
      test_reset();
      test_clean_rise();
      test_bounce();
      test_fall_simul();
      test_reset_mid_pending();
      test_random();
`ifdef SW_GLITCH_CNT_EN
      test_saturation();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
